// File: rtl/apb_sys_param.sv
// APB master FSM driving an internal register-file slave. A request on PTX becomes
// one SETUP/ACCESS transfer; DONE pulses and PRDATA/ERROR update when it completes.
module apb_sys_param #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PTX,
    input  logic                WRITE,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] STRB,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PREADY,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                DONE,
    output logic                ERROR,
    output logic [1:0]          dbg_state
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int CMP_W = (ADDR_W > 32) ? ADDR_W : 32;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_STATES);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SETUP  = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;

    logic [1:0]        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [NB-1:0]     pstrb;
    logic [DATA_W-1:0] regs [DEPTH];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              complete;
    logic              take;
    logic [DATA_W-1:0] rd_word;

    // Handshake: a request is accepted on any edge where PTX=1 and the master is
    // either idle or completing, so back-to-back requests skip the IDLE cycle.
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign PREADY    = (state == ACCESS) && (wait_cnt == WAIT_LAST);
    assign complete  = PREADY;
    assign take      = PTX && ((state == IDLE) || complete);
    assign in_range  = (CMP_W'(paddr) < CMP_W'(DEPTH));
    assign idx       = paddr[IDX_W-1:0];
    assign rd_word   = in_range ? regs[idx] : '0;
    assign dbg_state = state;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
            pstrb  <= '0;
        end else if (take) begin
            pwrite <= WRITE;
            paddr  <= ADDR;
            pwdata <= WDATA;
            pstrb  <= STRB;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state    <= IDLE;
            wait_cnt <= '0;
            DONE     <= 1'b0;
            ERROR    <= 1'b0;
            PRDATA   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (PTX) state <= SETUP;
                end
                SETUP: begin
                    state    <= ACCESS;
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (complete) begin
                        DONE  <= 1'b1;
                        ERROR <= !in_range;
                        if (!pwrite) PRDATA <= rd_word;
                        state <= PTX ? SETUP : IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Out-of-range and zero-strobe writes leave every register untouched.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (complete && pwrite && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (pstrb[b]) regs[idx][b*8 +: 8] <= pwdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: doc/apb_sys_param.md
APB_SYS_PARAM -- requirements
Module: apb_sys_param

Interface
REQ-001 Parameter ADDR_W, default 8, width of request address ADDR and bus address PADDR.
REQ-002 Parameter DATA_W, default 32, data width; SHALL be a multiple of 8.
REQ-003 Parameter DEPTH, default 16, number of DATA_W-bit registers in the slave register file.
REQ-004 Parameter WAIT_STATES, default 0, number of extra ACCESS cycles inserted before PREADY asserts.
REQ-005 PCLK  input  1  single clock; all state updates on rising edge.
REQ-006 PRESET  input  1  asynchronous, active-low reset.
REQ-007 PTX  input  1  transfer request, level-sensitive.
REQ-008 WRITE  input  1  1 = write, 0 = read; sampled with PTX.
REQ-009 ADDR  input  ADDR_W  word address; sampled with PTX.
REQ-010 WDATA  input  DATA_W  write data; sampled with PTX.
REQ-011 STRB  input  DATA_W/8  byte-lane write enables; sampled with PTX; ignored on reads.
REQ-012 PSEL, PENABLE, PREADY  output  1 each  internal APB bus phase signals, exported for observation.
REQ-013 PRDATA  output  DATA_W  read data of the last completed read.
REQ-014 DONE  output  1  one-cycle pulse per completed transfer.
REQ-015 ERROR  output  1  PSLVERR status of the last completed transfer.

Function
REQ-016 Master FSM SHALL have states IDLE (PSEL=0, PENABLE=0), SETUP (PSEL=1, PENABLE=0), ACCESS (PSEL=1, PENABLE=1).
REQ-017 IDLE with PTX=1 at an edge: latch WRITE/ADDR/WDATA/STRB, go to SETUP; IDLE with PTX=0 stays IDLE.
REQ-018 SETUP SHALL last exactly one cycle, then go to ACCESS unconditionally.
REQ-019 ACCESS: wait counter starts at 0, increments each cycle; PREADY=1 only while in ACCESS and counter==WAIT_STATES.
REQ-020 Completion edge: ACCESS with PREADY=1; next state SETUP if PTX=1 (new inputs latched at that edge, no IDLE cycle), else IDLE.
REQ-021 Latency: PTX sampled at edge e0 -> completion at edge e0+2+WAIT_STATES; DONE high for the one cycle after the completion edge.
REQ-022 Latched inputs SHALL be held stable on PADDR/PWDATA/PWRITE/PSTRB internally from SETUP through completion; input changes mid-transfer have no effect.
REQ-023 ADDR < DEPTH: write updates only byte lanes with STRB bit=1; read loads PRDATA with register contents; ERROR cleared to 0.
REQ-024 ADDR >= DEPTH (incl. upper bits of ADDR_W beyond DEPTH): ERROR=1, no register modified, PRDATA loaded with 0 on read.
REQ-025 Write with STRB=0: completes normally, ERROR=0, no data change.
REQ-026 PRDATA SHALL update only at read completion edges; held across writes and idle.
REQ-027 ERROR SHALL update at every completion edge and hold until the next.
REQ-028 PREADY SHALL never be 1 outside ACCESS; PENABLE never 1 without PSEL.

Reset
REQ-029 PRESET=0 SHALL immediately force state IDLE, wait counter 0, PSEL=PENABLE=PREADY=DONE=ERROR=0, PRDATA=0, all DEPTH registers 0.
REQ-030 Reset during SETUP or ACCESS SHALL abort the transfer: no register write, no DONE pulse.
REQ-031 After PRESET rises, first PTX=1 sampled starts a fresh transfer per REQ-017.

Verification
REQ-032 Defaults, write ADDR=0x05 WDATA=0xABCDABCD STRB=0xF, then read 0x05 -> DONE after each, PRDATA=0xABCDABCD, ERROR=0.
REQ-033 Write ADDR=0xA5 WDATA=0x12345678 -> ERROR=1, DONE pulses; read 0xA5 -> PRDATA=0, ERROR=1; all registers unchanged.
REQ-034 After REQ-032, write 0x05 WDATA=0x11223344 STRB=0x5, read 0x05 -> PRDATA=0xAB22AB44.
REQ-035 WAIT_STATES=2, single read -> PSEL 1 at e0+1, PENABLE 1 e0+2..e0+4, PREADY only in cycle after e0+3, DONE in cycle after e0+4.
REQ-036 PTX held high for two writes (0x01=0x1, 0x02=0x2) -> SETUP follows ACCESS directly, two DONE pulses 2+WAIT_STATES cycles apart, both registers written.
REQ-037 PRESET=0 asserted during ACCESS of write 0x03=0xFFFFFFFF -> outputs 0 immediately, no DONE; read 0x03 after release -> PRDATA=0.
